// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32 front end: NOP encoding, default reset PC
// and the fetch FSM state type.
package riscv_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        FAULT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory port: valid/ready request channel (address) and
// valid/ready response channel (instruction word).
interface instruction_fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        output imem_rsp_ready,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        input  imem_rsp_ready,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry valid/ready output register between fetch and decode.
// Flush wins over load, load wins over consume.
module fetch_buffer
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        consume,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    logic valid_d;

    always_comb begin
        valid_d = valid;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            instr    <= NOP;
            instr_pc <= 32'h0000_0000;
        end else begin
            valid <= valid_d;
            if (load && !flush) begin
                instr    <= load_instr;
                instr_pc <= load_pc;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one outstanding word request at a time and
// hands returned instructions to decode; redirects squash younger work.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    instruction_fetch_if.master        imem,
    input  logic                       instr_ready,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic                       fetch_fault,
    output logic [31:0]                fault_addr
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fault_addr_q, fault_addr_d;
    logic         discard_q, discard_d;
    logic         fault_q, fault_d;
    logic         load, flush;
    logic         rsp_ready, req_hs, rsp_hs;
    logic         redirect, misaligned;

    // Request side is purely registered; only rsp_ready sees instr_ready.
    assign imem.imem_req_valid = (state_q == REQ);
    assign imem.imem_addr      = pc_q;
    assign rsp_ready           = (state_q == FAULT)
                               | ((state_q == WAIT) & (discard_q | ~instr_valid | instr_ready));
    assign imem.imem_rsp_ready = rsp_ready;

    assign req_hs     = (state_q == REQ) & imem.imem_req_ready;
    assign rsp_hs     = (state_q == WAIT) & imem.imem_rsp_valid & rsp_ready;
    assign redirect   = redirect_valid & (state_q != FAULT);
    assign misaligned = redirect & (redirect_pc[1:0] != 2'b00);

    assign fetch_fault = fault_q;
    assign fault_addr  = fault_addr_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        load         = 1'b0;
        flush        = 1'b0;

        unique case (state_q)
            REQ: begin
                if (req_hs) state_d = WAIT;
            end
            WAIT: begin
                if (rsp_hs) begin
                    state_d = REQ;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            FAULT: ;
            default: ;
        endcase

        // A redirect overrides everything above; any response in flight belongs
        // to the squashed path and must be swallowed via discard.
        if (redirect) begin
            flush = 1'b1;
            load  = 1'b0;
            pc_d  = redirect_pc;
            if (misaligned) begin
                state_d      = FAULT;
                fault_d      = 1'b1;
                fault_addr_d = redirect_pc;
                discard_d    = req_hs | ((state_q == WAIT) & ~rsp_hs);
            end else if (state_q == REQ) begin
                discard_d = req_hs;
                state_d   = req_hs ? WAIT : REQ;
            end else begin
                discard_d = ~rsp_hs;
                state_d   = rsp_hs ? REQ : WAIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst        (reset),
        .load       (load),
        .flush      (flush),
        .consume    (instr_ready),
        .load_instr (imem.imem_rsp_data),
        .load_pc    (pc_q),
        .valid      (instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory model with programmable latency,
// program-order model of request/delivery addresses, and literal timing checks.
module tb_instruction_fetch;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;
    logic [31:0] fault_addr;

    always #5 clk = ~clk;

    instruction_fetch_if imem_bus ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault),
        .fault_addr     (fault_addr)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Program-order model
    logic [31:0] exp_req, exp_dlv, exp_fault;
    bit          in_fault, redir_prev;

    // Memory model
    bit          pending;
    int          wait_cnt, extra;
    logic [31:0] pend_data;

    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    logic [31:0] dlv_pc_q[$];
    int          dlv_cyc_q[$];

    // Snapshot of the last sampled cycle
    int          s_cyc;
    logic        s_valid, s_req_valid, s_rsp_ready, s_fault;
    logic [31:0] s_instr, s_pc, s_addr, s_faddr;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(int lat);
        reset                   = 1'b1;
        redirect_valid          = 1'b0;
        redirect_pc             = 32'h0;
        instr_ready             = 1'b1;
        imem_bus.imem_req_ready = 1'b1;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'h0;
        pending                 = 0;
        wait_cnt                = 0;
        extra                   = lat;
        repeat (2) @(posedge clk);
        #1;
        reset      = 1'b0;
        exp_req    = 32'h0;
        exp_dlv    = 32'h0;
        exp_fault  = 32'h0;
        in_fault   = 0;
        redir_prev = 0;
        cyc        = 0;
        req_addr_q.delete();
        req_cyc_q.delete();
        dlv_pc_q.delete();
        dlv_cyc_q.delete();
    endtask

    task automatic step();
        logic req_hs, rsp_hs, dlv;
        logic [31:0] addr_s;
        @(negedge clk);
        s_cyc       = cyc;
        s_valid     = instr_valid;
        s_instr     = instr;
        s_pc        = instr_pc;
        s_req_valid = imem_bus.imem_req_valid;
        s_addr      = imem_bus.imem_addr;
        s_rsp_ready = imem_bus.imem_rsp_ready;
        s_fault     = fetch_fault;
        s_faddr     = fault_addr;
        addr_s      = imem_bus.imem_addr;
        req_hs = imem_bus.imem_req_valid & imem_bus.imem_req_ready;
        rsp_hs = imem_bus.imem_rsp_valid & imem_bus.imem_rsp_ready;
        dlv    = instr_valid & instr_ready & ~redirect_valid;

        if (instr_valid) chk("instr_matches_mem", instr, mem_word(instr_pc));
        if (redir_prev) chk("flush_after_redirect", 32'(instr_valid), 32'd0);
        if (pending) chk("one_outstanding", 32'(imem_bus.imem_req_valid), 32'd0);
        if (in_fault) begin
            chk("fault_flag", 32'(fetch_fault), 32'd1);
            chk("fault_addr", fault_addr, exp_fault);
            chk("fault_no_req", 32'(imem_bus.imem_req_valid), 32'd0);
            chk("fault_rsp_ready", 32'(imem_bus.imem_rsp_ready), 32'd1);
            chk("fault_no_instr", 32'(instr_valid), 32'd0);
        end else begin
            chk("fault_clear", 32'(fetch_fault), 32'd0);
        end

        redir_prev = 0;
        if (!in_fault) begin
            if (req_hs) begin
                chk("req_addr", addr_s, exp_req);
                req_addr_q.push_back(addr_s);
                req_cyc_q.push_back(cyc);
                exp_req = exp_req + 32'd4;
            end
            if (dlv) begin
                chk("dlv_pc", instr_pc, exp_dlv);
                chk("dlv_instr", instr, mem_word(exp_dlv));
                dlv_pc_q.push_back(instr_pc);
                dlv_cyc_q.push_back(cyc);
                exp_dlv = exp_dlv + 32'd4;
            end
            if (redirect_valid) begin
                redir_prev = 1;
                if (redirect_pc[1:0] != 2'b00) begin
                    in_fault  = 1;
                    exp_fault = redirect_pc;
                end else begin
                    exp_req = redirect_pc;
                    exp_dlv = redirect_pc;
                end
            end
        end

        @(posedge clk);
        #1;
        if (rsp_hs) begin
            imem_bus.imem_rsp_valid = 1'b0;
            pending = 0;
        end
        if (req_hs) begin
            pending   = 1;
            wait_cnt  = extra;
            pend_data = mem_word(addr_s);
        end
        if (pending && !imem_bus.imem_rsp_valid) begin
            if (wait_cnt == 0) begin
                imem_bus.imem_rsp_valid = 1'b1;
                imem_bus.imem_rsp_data  = pend_data;
            end else begin
                wait_cnt--;
            end
        end
        redirect_valid = 1'b0;
        cyc++;
    endtask

    task automatic check_reset_vals();
        chk("rst_instr_valid", 32'(s_valid), 32'd0);
        chk("rst_instr", s_instr, NOP);
        chk("rst_instr_pc", s_pc, 32'h0);
        chk("rst_fetch_fault", 32'(s_fault), 32'd0);
        chk("rst_fault_addr", s_faddr, 32'h0);
        chk("rst_req_valid", 32'(s_req_valid), 32'd1);
        chk("rst_imem_addr", s_addr, 32'h0);
    endtask

    task automatic redir(logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    initial begin
        // Streaming from reset with a 1-cycle memory
        do_reset(0);
        for (int i = 0; i < 7; i++) begin
            step();
            if (s_cyc == 0) check_reset_vals();
            if (s_cyc == 3) chk("s1_gap_cycle3", 32'(s_valid), 32'd0);
        end
        chk("s1_dlv_count", 32'(dlv_pc_q.size()), 32'd3);
        if (dlv_pc_q.size() == 3) begin
            chk("s1_dlv0_cyc", 32'(dlv_cyc_q[0]), 32'd2);
            chk("s1_dlv1_cyc", 32'(dlv_cyc_q[1]), 32'd4);
            chk("s1_dlv2_pc", dlv_pc_q[2], 32'h8);
            chk("s1_dlv2_cyc", 32'(dlv_cyc_q[2]), 32'd6);
        end

        // Decode stall for 5 cycles
        do_reset(0);
        for (int i = 0; i < 11; i++) begin
            instr_ready = !(cyc >= 3 && cyc <= 7);
            step();
            if (s_cyc == 6) begin
                chk("s2_hold_valid", 32'(s_valid), 32'd1);
                chk("s2_hold_pc", s_pc, 32'h4);
                chk("s2_rsp_ready", 32'(s_rsp_ready), 32'd0);
                chk("s2_rsp_waits", 32'(imem_bus.imem_rsp_valid), 32'd1);
            end
        end
        chk("s2_dlv_count", 32'(dlv_pc_q.size()), 32'd3);
        if (dlv_pc_q.size() == 3) begin
            chk("s2_dlv1_pc", dlv_pc_q[1], 32'h4);
            chk("s2_dlv1_cyc", 32'(dlv_cyc_q[1]), 32'd8);
            chk("s2_dlv2_pc", dlv_pc_q[2], 32'h8);
            chk("s2_dlv2_cyc", 32'(dlv_cyc_q[2]), 32'd9);
        end
        chk("s2_req_8_cycle", 32'(req_cyc_q[2]), 32'd4);

        // Redirect while 0x8 is outstanding (2-cycle memory)
        do_reset(1);
        for (int i = 0; i < 14; i++) begin
            if (cyc == 7) redir(32'h100);
            step();
            if (s_cyc == 8) chk("s3_drain_rsp_ready", 32'(s_rsp_ready), 32'd1);
        end
        chk("s3_req_count", 32'(req_addr_q.size()), 32'd5);
        if (req_addr_q.size() >= 4) begin
            chk("s3_req3_addr", req_addr_q[3], 32'h100);
            chk("s3_req3_cyc", 32'(req_cyc_q[3]), 32'd9);
        end
        chk("s3_dlv_count", 32'(dlv_pc_q.size()), 32'd3);
        if (dlv_pc_q.size() == 3) begin
            chk("s3_dlv2_pc", dlv_pc_q[2], 32'h100);
            chk("s3_dlv2_cyc", 32'(dlv_cyc_q[2]), 32'd12);
        end

        // Redirect coinciding with a response; buffered 0x0 is flushed
        do_reset(0);
        for (int i = 0; i < 9; i++) begin
            instr_ready = !(cyc == 2 || cyc == 3);
            if (cyc == 4) redir(32'h200);
            step();
        end
        chk("s4_dlv_count", 32'(dlv_pc_q.size()), 32'd1);
        if (dlv_pc_q.size() == 1) begin
            chk("s4_dlv0_pc", dlv_pc_q[0], 32'h200);
            chk("s4_dlv0_cyc", 32'(dlv_cyc_q[0]), 32'd7);
        end
        if (req_addr_q.size() >= 3) begin
            chk("s4_req2_addr", req_addr_q[2], 32'h200);
            chk("s4_req2_cyc", 32'(req_cyc_q[2]), 32'd5);
        end else begin
            chk("s4_req_count", 32'(req_addr_q.size()), 32'd4);
        end

        // Misaligned redirect, ignored redirect in FAULT, then reset
        do_reset(0);
        for (int i = 0; i < 10; i++) begin
            if (cyc == 2) redir(32'h102);
            if (cyc == 6) redir(32'h300);
            step();
        end
        chk("s5_fault", 32'(s_fault), 32'd1);
        chk("s5_fault_addr", s_faddr, 32'h102);
        chk("s5_req_count", 32'(req_addr_q.size()), 32'd2);
        chk("s5_dlv_count", 32'(dlv_pc_q.size()), 32'd0);
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_cyc == 0) check_reset_vals();
        end
        chk("s5_restart_count", 32'(dlv_pc_q.size()), 32'd1);
        if (dlv_pc_q.size() == 1) chk("s5_restart_pc", dlv_pc_q[0], 32'h0);

        // PC wrap at the top of the address space
        do_reset(0);
        for (int i = 0; i < 9; i++) begin
            if (cyc == 2) redir(32'hFFFF_FFFC);
            step();
        end
        chk("s6_dlv_count", 32'(dlv_pc_q.size()), 32'd2);
        if (dlv_pc_q.size() == 2) begin
            chk("s6_dlv0_pc", dlv_pc_q[0], 32'hFFFF_FFFC);
            chk("s6_dlv0_instr", mem_word(dlv_pc_q[0]), 32'hA5A5_FFEF);
            chk("s6_dlv1_pc", dlv_pc_q[1], 32'h0);
        end
        if (req_addr_q.size() >= 4) chk("s6_wrap_addr", req_addr_q[3], 32'h0);
        else chk("s6_req_count", 32'(req_addr_q.size()), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RISC-V 32 core: holds the program counter and issues word-aligned requests to the instruction memory over a valid/ready port. It presents each returned instruction with its PC to decode through a one-entry output buffer; decode and the immediate extender consume that buffer. Taken branches and jumps redirect the PC, and in-flight or buffered younger instructions are discarded.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be 4-byte aligned.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address (= pc).
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_ready  out  1  fetch accepts response.
- imem_rsp_data  in  32  fetched instruction word.
- instr_valid  out  1  output buffer holds an instruction.
- instr_ready  in  1  decode consumes the buffer this cycle.
- instr  out  32  buffered instruction.
- instr_pc  out  32  PC of the buffered instruction.
- fetch_fault  out  1  sticky misaligned-redirect fault.
- fault_addr  out  32  offending redirect_pc.

## Operation
- The state machine has three states: REQ, WAIT and FAULT. It also holds the registers pc, discard, the output buffer (valid, instr, instr_pc) and fault_addr.
- Reset values:
  - state=REQ, pc=RESET_PC, discard=0.
  - instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0.
  - fetch_fault=0, fault_addr=0.
- REQ:
  - Drives imem_req_valid=1 and imem_addr=pc.
  - On handshake (req_valid & req_ready), go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - imem_rsp_ready = discard | !instr_valid | instr_ready.
  - On response handshake with discard=1: clear discard, go to REQ, leave the buffer unchanged.
  - On response handshake with discard=0: load the buffer with instr=imem_rsp_data and instr_pc=pc, set instr_valid=1, pc<=pc+4, go to REQ.
- Buffer: instr_valid clears on instr_ready when no new load happens the same cycle. A load and a consume in the same cycle leave instr_valid=1 with the new contents.
- PC arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Redirect (any state except FAULT) has priority over all other updates:
  - pc<=redirect_pc and instr_valid<=0; the buffered instruction is flushed even if instr_ready=1.
  - In REQ with a request handshake the same cycle: discard<=1, go to WAIT.
  - In WAIT with no response handshake the same cycle: discard<=1, stay in WAIT.
  - In WAIT with a response handshake the same cycle: drop the response, discard<=0, go to REQ.
  - In REQ with no handshake: stay in REQ; the next request uses the new pc.
- Misaligned redirect (redirect_valid and redirect_pc[1:0]!=0):
  - Go to FAULT, set fetch_fault=1 and fault_addr=redirect_pc, clear instr_valid.
  - If a request is outstanding, or is accepted that same cycle, set discard=1.
- FAULT:
  - imem_req_valid=0, imem_rsp_ready=1, and any response is dropped.
  - redirect_valid is ignored.
  - Exit only through reset.
- Reset asserted mid-operation immediately forces all reset values. The instruction memory shares this reset, so no stale response survives it.

## Timing
- imem_req_valid and imem_addr depend only on registered state, with no combinational path from imem_req_ready or redirect_*.
- imem_rsp_ready depends combinationally on instr_ready; this is the only input-to-output combinational path.
- At most one request is outstanding.
- With a memory that answers the cycle after acceptance: the request is issued in cycle N, the response arrives in N+1, instr_valid rises in N+2, and the next request is issued in N+2. Peak throughput is one instruction per 2 cycles.
- A redirect in cycle N gives instr_valid=0 in N+1. The first request to the target is in N+1, or when the outstanding response has drained.

## Structure
- Shared package riscv_pkg holds:
  - the NOP constant 32'h0000_0013;
  - the default RESET_PC;
  - the enum fetch_state_t {REQ, WAIT, FAULT}.
- Natural sub-module: fetch_buffer, the one-entry valid/ready output register (load, consume, flush); the FSM and pc stay in instruction_fetch.

## Test plan
- Reset release with the memory always ready at 1-cycle latency: addresses 0, 4, 8… are issued; instr/instr_pc pairs match memory contents; one instr_valid pulse every 2 cycles.
- instr_ready held 0 for 5 cycles: the buffer holds the instruction at PC 0x4, the request for 0x8 is issued, imem_rsp_ready=0 and the 0x8 response waits; on release the 0x4 and 0x8 instructions both appear, in order.
- Redirect to 0x100 while the request for 0x8 is outstanding: the 0x8 response is dropped, the next imem_addr is 0x100, and instr_pc 0x100 is the next one decode sees.
- Redirect to 0x200 in the same cycle as a response: that response is dropped, the buffer is flushed, and the next request is to 0x200.
- Redirect to 0x102: fetch_fault=1 and fault_addr=0x102; no further requests; a later redirect to 0x300 is ignored; reset clears the fault and fetching restarts at RESET_PC.
- Redirect to 32'hFFFF_FFFC: the instruction there is delivered, and the next imem_addr is 0 (wrap).
